// File: rtl/limber_ram_icb_master.sv
// Command/response front-end for a single-port RAM with a 1-cycle registered read.
// Commands issue to the RAM in the accept cycle; responses land in a 3-entry in-order FIFO.
module limber_ram_icb_master #(
  parameter int DP = 1024,
  parameter int DW = 16,
  parameter int MW = 2,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [MW-1:0] cmd_wmask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned DP_U = DP;

  // Handshake contract: a transfer happens on a rising edge where valid and ready
  // are both high; ready never depends on valid, and cmd_ready ignores rsp_ready.

  logic [1:0]    occ;
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic          p_valid;
  logic          p_read;
  logic          p_err;
  logic [DW-1:0] fifo_rdata [0:2];
  logic          fifo_err   [0:2];
  logic [2:0]    pending;
  logic          acc;
  logic          in_range;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Counting the stage-P entry reserves its FIFO slot before it lands.
  assign pending   = {1'b0, occ} + {2'b00, p_valid};
  assign cmd_ready = ~rst & (pending < 3'd3);
  assign acc       = cmd_valid & cmd_ready;
  assign in_range  = 32'(cmd_addr) < DP_U;

  assign ram_cs   = acc & in_range;
  assign ram_we   = ram_cs & ~cmd_read;
  assign ram_wem  = ram_we ? cmd_wmask : '0;
  assign ram_addr = cmd_addr;
  assign ram_din  = cmd_wdata;

  assign push      = p_valid;
  assign pop       = rsp_valid & rsp_ready;
  assign push_data = (p_read & ~p_err) ? ram_dout : '0;

  assign rsp_valid = ~rst & (occ != 2'd0);
  assign rsp_rdata = rsp_valid ? fifo_rdata[rd_ptr] : '0;
  assign rsp_err   = rsp_valid & fifo_err[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_read  <= 1'b0;
      p_err   <= 1'b0;
      occ     <= 2'd0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
    end else begin
      p_valid <= acc;
      if (acc) begin
        p_read <= cmd_read;
        p_err  <= ~in_range;
      end
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_rdata[wr_ptr] <= push_data;
      fifo_err[wr_ptr]   <= p_err;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (occ == 2'd3) && !pop))
    else $error("response FIFO overflow");

endmodule

// File: tb/tb_limber_ram_icb_master.sv
// Bench for limber_ram_icb_master: behavioural RAM, queue-based response model
// checked every cycle, and directed scenarios with literal expectations.
module tb_limber_ram_icb_master;
  localparam int DP = 1024;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          ram_cs;
  logic          ram_we;
  logic [MW-1:0] ram_wem;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  limber_ram_icb_master #(.DP(DP), .DW(DW), .MW(MW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with registered read
  logic [DW-1:0] mem [0:DP-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < MW; b++)
          if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: every accepted command owes one in-order response, visible from two cycles after acceptance.
  logic [DW-1:0] ref_mem [0:DP-1];
  logic [DW:0]   exp_q[$];
  int            exp_cyc_q[$];
  logic [DW:0]   got_q[$];
  int            got_cyc_q[$];

  always @(negedge clk) begin
    logic exp_valid;
    logic acc;
    logic in_range;
    if (rst) begin
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ram_cs", ram_cs, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_wem", ram_wem, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      check("cmd_ready", cmd_ready, exp_q.size() < 3);
      exp_valid = (exp_q.size() > 0) && (cyc >= exp_cyc_q[0] + 2);
      check("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        check("rsp_rdata", rsp_rdata, exp_q[0][DW-1:0]);
        check("rsp_err", rsp_err, exp_q[0][DW]);
      end
      acc = cmd_valid && (exp_q.size() < 3);
      in_range = cmd_addr < DP;
      if (acc && in_range) begin
        check("ram_cs", ram_cs, 1);
        check("ram_we", ram_we, !cmd_read);
        check("ram_wem", ram_wem, cmd_read ? 0 : cmd_wmask);
        check("ram_addr", ram_addr, cmd_addr);
        check("ram_din", ram_din, cmd_wdata);
      end else begin
        check("ram_cs_idle", ram_cs, 0);
        check("ram_we_idle", ram_we, 0);
        check("ram_wem_idle", ram_wem, 0);
      end
      if (exp_valid && rsp_ready) begin
        got_q.push_back({rsp_err, rsp_rdata});
        got_cyc_q.push_back(cyc);
        exp_q.pop_front();
        exp_cyc_q.pop_front();
      end
      if (acc) begin
        if (!in_range) exp_q.push_back({1'b1, {DW{1'b0}}});
        else if (cmd_read) exp_q.push_back({1'b0, ref_mem[cmd_addr]});
        else begin
          for (int b = 0; b < MW; b++)
            if (cmd_wmask[b]) ref_mem[cmd_addr][b*8 +: 8] = cmd_wdata[b*8 +: 8];
          exp_q.push_back('0);
        end
        exp_cyc_q.push_back(cyc);
      end
    end
    cyc++;
  end

  // Driver: called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [MW-1:0] wm, output logic cs);
    int n;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wmask = wm;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    cs = ram_cs;
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: addr %0h never accepted, required accept within 50 cycles", addr);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    logic cs;
    int   base;
    int   accepted;
    logic acc_now;
    rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);
    @(posedge clk); #1;

    // Write then read, with latency pinned on an empty FIFO
    base = got_q.size();
    send(1'b0, 11'd5, 16'hBEEF, 2'b11, cs);
    send(1'b1, 11'd5, 16'h0000, 2'b00, cs);
    drain();
    check("wr5_rsp", got_q[base], 17'h00000);
    check("rd5_rsp", got_q[base+1], {1'b0, 16'hBEEF});
    send(1'b1, 11'd5, 16'h0000, 2'b00, cs);
    @(negedge clk);
    check("lat_n1", rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_n2", rsp_valid, 1);
    check("lat_n2_data", rsp_rdata, 16'hBEEF);
    @(posedge clk); #1;
    drain();

    // Byte masking, then a zero-mask write that must leave RAM untouched
    base = got_q.size();
    send(1'b0, 11'd7, 16'h1234, 2'b11, cs);
    send(1'b0, 11'd7, 16'hAB00, 2'b10, cs);
    send(1'b1, 11'd7, 16'h0000, 2'b00, cs);
    send(1'b0, 11'd7, 16'hFFFF, 2'b00, cs);
    check("zero_mask_cs", cs, 1);
    send(1'b1, 11'd7, 16'h0000, 2'b00, cs);
    drain();
    check("mask_rd", got_q[base+2], {1'b0, 16'hAB34});
    check("zero_mask_rsp", got_q[base+3], 17'h00000);
    check("zero_mask_rd", got_q[base+4], {1'b0, 16'hAB34});

    // Read-after-write on consecutive cycles
    base = got_q.size();
    send(1'b0, 11'd9, 16'h5A5A, 2'b11, cs);
    send(1'b1, 11'd9, 16'h0000, 2'b00, cs);
    drain();
    check("raw_rd", got_q[base+1], {1'b0, 16'h5A5A});

    // Range boundary
    base = got_q.size();
    send(1'b0, 11'd1023, 16'h7E57, 2'b11, cs);
    send(1'b1, 11'd1023, 16'h0000, 2'b00, cs);
    check("in_range_cs", cs, 1);
    send(1'b1, 11'd1024, 16'h0000, 2'b00, cs);
    check("out_range_cs", cs, 0);
    drain();
    check("rd1023", got_q[base+1], {1'b0, 16'h7E57});
    check("rd1024_err", got_q[base+2], {1'b1, 16'h0000});

    // Prefill 0..15
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), 16'hC000 | 16'(i), 2'b11, cs);
    drain();

    // Backpressure: only three commands fit while responses are blocked
    base = got_q.size();
    rsp_ready = 1'b0;
    accepted = 0;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = '0; cmd_wmask = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acc_now = cmd_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        accepted++;
        cmd_addr = AW'(accepted);
      end
    end
    cmd_valid = 1'b0;
    check("bp_accepted", accepted, 3);
    @(negedge clk);
    check("bp_full", cmd_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle", cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_again", cmd_ready, 1);
    @(posedge clk); #1;
    send(1'b1, 11'd3, 16'h0000, 2'b00, cs);
    send(1'b1, 11'd4, 16'h0000, 2'b00, cs);
    drain();
    check("bp_count", got_q.size() - base, 5);
    for (int i = 0; i < 5; i++) check("bp_data", got_q[base+i], {1'b0, 16'hC000 | 16'(i)});

    // Throughput: one command and one response per cycle
    base = got_q.size();
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), 16'h0000, 2'b00, cs);
    drain();
    check("tp_count", got_q.size() - base, 16);
    check("tp_span", got_cyc_q[base+15] - got_cyc_q[base], 15);
    for (int i = 0; i < 16; i++) check("tp_data", got_q[base+i], {1'b0, 16'hC000 | 16'(i)});

    // Reset with two buffered responses and one in stage P
    rsp_ready = 1'b0;
    send(1'b1, 11'd10, 16'h0000, 2'b00, cs);
    send(1'b1, 11'd11, 16'h0000, 2'b00, cs);
    send(1'b1, 11'd12, 16'h0000, 2'b00, cs);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", rsp_valid, 0);
      @(posedge clk); #1;
    end
    base = got_q.size();
    send(1'b1, 11'd12, 16'h0000, 2'b00, cs);
    drain();
    check("post_rst_count", got_q.size() - base, 1);
    check("post_rst_rd", got_q[base], {1'b0, 16'hC00C});

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
